// File: rtl/wb_rr_arbiter.sv
// Two-master round-robin Wishbone (pipelined, stall) arbiter with outstanding tracking and response watchdog.
// Grant 1 cycle after request, responses pass through combinationally; owner is stalled while MAX_OUTST requests are in flight.
module wb_rr_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int GRANULE    = 8,
  parameter int TIMEOUT    = 64,
  parameter int MAX_OUTST  = 15,
  localparam int SEL_WIDTH = DATA_WIDTH / GRANULE
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [1:0]              m_cyc_i,
  input  logic [1:0]              m_stb_i,
  input  logic [1:0]              m_we_i,
  input  logic [2*ADDR_WIDTH-1:0] m_adr_i,
  input  logic [2*DATA_WIDTH-1:0] m_dat_i,
  input  logic [2*SEL_WIDTH-1:0]  m_sel_i,
  output logic [DATA_WIDTH-1:0]   m_dat_o,
  output logic [1:0]              m_ack_o,
  output logic [1:0]              m_err_o,
  output logic [1:0]              m_stall_o,
  output logic                    s_cyc_o,
  output logic                    s_stb_o,
  output logic                    s_we_o,
  output logic [ADDR_WIDTH-1:0]   s_adr_o,
  output logic [DATA_WIDTH-1:0]   s_dat_o,
  output logic [SEL_WIDTH-1:0]    s_sel_o,
  input  logic [DATA_WIDTH-1:0]   s_dat_i,
  input  logic                    s_ack_i,
  input  logic                    s_err_i,
  input  logic                    s_stall_i,
  output logic [1:0]              grant_o,
  output logic                    timeout_o
);

  typedef enum logic [1:0] {IDLE, BUSY, ABORT} state_e;

  state_e     state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic       last_q, last_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] timer_q, timer_d;
  logic       first_q, first_d;

  logic own;
  logic owner_cyc;
  logic full;
  logic resp;
  logic accept;
  logic pick;

  assign own       = grant_q[1];
  assign owner_cyc = m_cyc_i[own];
  assign full      = (cnt_q == 4'(MAX_OUTST));
  assign resp      = s_ack_i | s_err_i;
  assign accept    = s_stb_o & ~s_stall_i;
  // On contention the master that did not win last time gets the bus.
  assign pick      = (m_cyc_i == 2'b11) ? ~last_q : m_cyc_i[1];
  assign grant_o   = grant_q;

  always_comb begin
    s_cyc_o   = 1'b0;
    s_stb_o   = 1'b0;
    s_we_o    = 1'b0;
    s_adr_o   = '0;
    s_dat_o   = '0;
    s_sel_o   = '0;
    m_dat_o   = '0;
    m_ack_o   = 2'b00;
    m_err_o   = 2'b00;
    m_stall_o = 2'b11;
    timeout_o = 1'b0;
    if (state_q != IDLE) begin
      s_we_o  = m_we_i[own];
      s_adr_o = own ? m_adr_i[2*ADDR_WIDTH-1:ADDR_WIDTH] : m_adr_i[ADDR_WIDTH-1:0];
      s_dat_o = own ? m_dat_i[2*DATA_WIDTH-1:DATA_WIDTH] : m_dat_i[DATA_WIDTH-1:0];
      s_sel_o = own ? m_sel_i[2*SEL_WIDTH-1:SEL_WIDTH]   : m_sel_i[SEL_WIDTH-1:0];
      m_dat_o = s_dat_i;
    end
    if (state_q == BUSY) begin
      s_cyc_o        = owner_cyc;
      s_stb_o        = m_stb_i[own] & ~full;
      m_stall_o[own] = s_stall_i | full;
      m_ack_o[own]   = s_ack_i;
      m_err_o[own]   = s_err_i;
    end
    if (state_q == ABORT && first_q) begin
      m_err_o[own] = 1'b1;
      timeout_o    = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    timer_d = timer_q;
    first_d = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d   = '0;
        timer_d = '0;
        if (|m_cyc_i) begin
          state_d = BUSY;
          grant_d = pick ? 2'b10 : 2'b01;
          last_d  = pick;
        end
      end
      BUSY: begin
        cnt_d   = cnt_q + {3'b000, accept} - {3'b000, resp & (cnt_q != 4'd0)};
        timer_d = (cnt_q == 4'd0 || resp) ? 8'd0 : timer_q + 8'd1;
        if (!owner_cyc) begin
          // Late responses to an abandoned tenure are dropped with the owner.
          state_d = IDLE;
          grant_d = 2'b00;
          cnt_d   = '0;
          timer_d = '0;
        end else if (cnt_q != 4'd0 && !resp && timer_q == 8'(TIMEOUT - 1)) begin
          state_d = ABORT;
          cnt_d   = '0;
          timer_d = '0;
          first_d = 1'b1;
        end
      end
      ABORT: begin
        if (!owner_cyc) begin
          state_d = IDLE;
          grant_d = 2'b00;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      timer_q <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      timer_q <= timer_d;
      first_q <= first_d;
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter: main instance uses TIMEOUT=64, a second TIMEOUT=8 copy shares inputs for the watchdog.
module tb_wb_rr_arbiter;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int SW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic [1:0]      m_cyc, m_stb, m_we;
  logic [2*AW-1:0] m_adr;
  logic [2*DW-1:0] m_dat;
  logic [2*SW-1:0] m_sel;
  logic [DW-1:0]   s_rdat;
  logic            s_ack, s_err, s_stall;

  logic [DW-1:0] m_rdat;
  logic [1:0]    m_ack, m_err, m_stall, grant;
  logic          s_cyc, s_stb, s_we, tmo;
  logic [AW-1:0] s_adr;
  logic [DW-1:0] s_wdat;
  logic [SW-1:0] s_sel;

  logic [DW-1:0] t_rdat;
  logic [1:0]    t_ack, t_err, t_stall, t_grant;
  logic          t_cyc, t_stb, t_we, t_tmo;
  logic [AW-1:0] t_adr;
  logic [DW-1:0] t_wdat;
  logic [SW-1:0] t_sel;

  int vecs = 0;
  int errs = 0;

  wb_rr_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .GRANULE(8), .TIMEOUT(64), .MAX_OUTST(15)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we),
    .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel),
    .m_dat_o(m_rdat), .m_ack_o(m_ack), .m_err_o(m_err), .m_stall_o(m_stall),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we),
    .s_adr_o(s_adr), .s_dat_o(s_wdat), .s_sel_o(s_sel),
    .s_dat_i(s_rdat), .s_ack_i(s_ack), .s_err_i(s_err), .s_stall_i(s_stall),
    .grant_o(grant), .timeout_o(tmo)
  );

  wb_rr_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .GRANULE(8), .TIMEOUT(8), .MAX_OUTST(15)) dut_to (
    .clk_i(clk), .rst_ni(rst_n),
    .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we),
    .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel),
    .m_dat_o(t_rdat), .m_ack_o(t_ack), .m_err_o(t_err), .m_stall_o(t_stall),
    .s_cyc_o(t_cyc), .s_stb_o(t_stb), .s_we_o(t_we),
    .s_adr_o(t_adr), .s_dat_o(t_wdat), .s_sel_o(t_sel),
    .s_dat_i(s_rdat), .s_ack_i(s_ack), .s_err_i(s_err), .s_stall_i(s_stall),
    .grant_o(t_grant), .timeout_o(t_tmo)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; m_cyc = 2'b11; m_stb = 2'b11; m_we = 2'b10;
    m_adr = {16'hB111, 16'hA000}; m_dat = {32'hB1B1_0002, 32'hA0A0_0001}; m_sel = 8'hC3;
    s_rdat = 32'hDEAD_BEEF; s_ack = 1'b1; s_err = 1'b1; s_stall = 1'b0;
    step(); step(); #1;
    vecs++; if (grant !== 2'b00) begin errs++; $display("FAIL reset_grant: got %b want 00", grant); end
    vecs++; if ({s_cyc, s_stb, s_we} !== 3'b000) begin errs++; $display("FAIL reset_ctrl: got %b want 000", {s_cyc, s_stb, s_we}); end
    vecs++; if ({s_adr, s_wdat, s_sel} !== '0) begin errs++; $display("FAIL reset_datapath: got %h want 0", {s_adr, s_wdat, s_sel}); end
    vecs++; if ({m_ack, m_err} !== 4'b0000) begin errs++; $display("FAIL reset_resp: got %b want 0000", {m_ack, m_err}); end
    vecs++; if (m_stall !== 2'b11) begin errs++; $display("FAIL reset_stall: got %b want 11", m_stall); end
    vecs++; if (tmo !== 1'b0) begin errs++; $display("FAIL reset_timeout: got %b want 0", tmo); end
    s_ack = 1'b0; s_err = 1'b0;
  endtask

  task automatic test_contention();
    rst_n = 1'b1;
    step(); #1;
    vecs++; if (grant !== 2'b01) begin errs++; $display("FAIL cont_grant0: got %b want 01", grant); end
    vecs++; if ({s_cyc, s_stb, s_we} !== 3'b110) begin errs++; $display("FAIL cont_ctrl0: got %b want 110", {s_cyc, s_stb, s_we}); end
    vecs++; if ({s_adr, s_wdat, s_sel} !== {16'hA000, 32'hA0A0_0001, 4'h3}) begin errs++; $display("FAIL cont_mux0: got %h want a000a0a000013", {s_adr, s_wdat, s_sel}); end
    vecs++; if (m_stall !== 2'b10) begin errs++; $display("FAIL cont_stall0: got %b want 10", m_stall); end
    step();
    m_cyc = 2'b10; m_stb = 2'b10; #1;
    vecs++; if (s_cyc !== 1'b0) begin errs++; $display("FAIL cont_drop_cyc: got %b want 0", s_cyc); end
    step();
    m_cyc = 2'b11; m_stb = 2'b11; #1;
    vecs++; if ({grant, m_stall} !== 4'b0011) begin errs++; $display("FAIL cont_idle_gap: got %b want 0011", {grant, m_stall}); end
    step(); #1;
    vecs++; if (grant !== 2'b10) begin errs++; $display("FAIL cont_grant1: got %b want 10", grant); end
    vecs++; if ({s_adr, s_we, s_sel} !== {16'hB111, 1'b1, 4'hC}) begin errs++; $display("FAIL cont_mux1: got %h want %h", {s_adr, s_we, s_sel}, {16'hB111, 1'b1, 4'hC}); end
    vecs++; if (m_stall !== 2'b01) begin errs++; $display("FAIL cont_stall1: got %b want 01", m_stall); end
    step();
    m_cyc = 2'b01; m_stb = 2'b01;
    step();
    m_cyc = 2'b11; m_stb = 2'b11;
    step(); #1;
    vecs++; if (grant !== 2'b01) begin errs++; $display("FAIL cont_grant2: got %b want 01", grant); end
    m_cyc = 2'b00; m_stb = 2'b00;
    step();
  endtask

  task automatic test_burst();
    int acks1;
    int ack0_seen;
    int tmo_seen;
    logic exp_stb;
    acks1 = 0; ack0_seen = 0; tmo_seen = 0;
    m_cyc = 2'b10; m_stb = 2'b00;
    step(); #1;
    vecs++; if (grant !== 2'b10) begin errs++; $display("FAIL burst_grant: got %b want 10", grant); end
    for (int i = 0; i < 8; i++) begin
      exp_stb = (i < 4);
      m_stb   = {exp_stb, 1'b0};
      s_ack   = (i >= 2 && i < 6);
      s_rdat  = 32'hD0D0_0000 | i;
      #1;
      vecs++; if ({s_stb, m_stall} !== {exp_stb, 2'b01}) begin errs++; $display("FAIL burst_stb_c%0d: got %b want %b", i, {s_stb, m_stall}, {exp_stb, 2'b01}); end
      if (m_ack[1] === 1'b1) begin
        acks1++;
        vecs++; if (m_rdat !== (32'hD0D0_0000 | i)) begin errs++; $display("FAIL burst_rdat_c%0d: got %h want %h", i, m_rdat, 32'hD0D0_0000 | i); end
      end
      if (m_ack[0] !== 1'b0) ack0_seen++;
      step();
    end
    s_ack = 1'b0;
    vecs++; if (acks1 !== 4) begin errs++; $display("FAIL burst_ack1_count: got %0d want 4", acks1); end
    vecs++; if (ack0_seen !== 0) begin errs++; $display("FAIL burst_ack0: got %0d pulses want 0", ack0_seen); end
    for (int i = 0; i < 10; i++) begin
      step();
      if (t_tmo !== 1'b0) tmo_seen++;
    end
    vecs++; if ({tmo_seen != 0, t_grant} !== 3'b010) begin errs++; $display("FAIL burst_count_drained: got tmo=%0d grant=%b want tmo=0 grant=10", tmo_seen, t_grant); end
    m_cyc = 2'b00;
    step();
  endtask

  task automatic test_full_stall();
    m_cyc = 2'b01; m_stb = 2'b01; s_ack = 1'b0; s_stall = 1'b0;
    step();
    for (int i = 0; i < 15; i++) begin
      #1;
      vecs++; if ({s_stb, m_stall} !== 3'b110) begin errs++; $display("FAIL full_fill_%0d: got %b want 110", i, {s_stb, m_stall}); end
      step();
    end
    #1;
    vecs++; if ({s_stb, m_stall} !== 3'b011) begin errs++; $display("FAIL full_at15: got %b want 011", {s_stb, m_stall}); end
    step();
    s_ack = 1'b1; #1;
    vecs++; if ({s_stb, m_ack} !== 3'b001) begin errs++; $display("FAIL full_ack: got %b want 001", {s_stb, m_ack}); end
    step();
    s_ack = 1'b0; #1;
    vecs++; if ({s_stb, m_stall} !== 3'b110) begin errs++; $display("FAIL full_at14: got %b want 110", {s_stb, m_stall}); end
    step(); #1;
    vecs++; if ({s_stb, m_stall} !== 3'b011) begin errs++; $display("FAIL full_refill: got %b want 011", {s_stb, m_stall}); end
    m_cyc = 2'b00; m_stb = 2'b00;
    step();
  endtask

  task automatic test_timeout();
    m_cyc = 2'b10; m_stb = 2'b10; s_ack = 1'b0;
    step(); #1;
    vecs++; if ({t_grant, t_cyc, t_stb} !== 4'b1011) begin errs++; $display("FAIL to_accept: got %b want 1011", {t_grant, t_cyc, t_stb}); end
    step();
    m_stb = 2'b00;
    for (int k = 1; k <= 8; k++) begin
      #1;
      vecs++; if ({t_tmo, t_err, t_cyc} !== 4'b0001) begin errs++; $display("FAIL to_wait_c%0d: got %b want 0001", k, {t_tmo, t_err, t_cyc}); end
      step();
    end
    s_ack = 1'b1; #1;
    vecs++; if ({t_tmo, t_err} !== 3'b110) begin errs++; $display("FAIL to_pulse: got %b want 110", {t_tmo, t_err}); end
    vecs++; if ({t_cyc, t_stall, t_ack} !== 5'b01100) begin errs++; $display("FAIL to_abort_bus: got %b want 01100", {t_cyc, t_stall, t_ack}); end
    step();
    s_ack = 1'b0; #1;
    vecs++; if ({t_tmo, t_err, t_cyc} !== 4'b0000) begin errs++; $display("FAIL to_pulse_end: got %b want 0000", {t_tmo, t_err, t_cyc}); end
    m_cyc = 2'b00;
    step(); #1;
    vecs++; if ({t_grant, t_stall} !== 4'b0011) begin errs++; $display("FAIL to_idle: got %b want 0011", {t_grant, t_stall}); end
  endtask

  task automatic test_simul();
    m_cyc = 2'b01; m_stb = 2'b01; s_ack = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      #1;
      vecs++; if (s_stb !== 1'b1) begin errs++; $display("FAIL simul_pre_%0d: got %b want 1", i, s_stb); end
      step();
    end
    s_ack = 1'b1; #1;
    vecs++; if ({s_stb, m_ack} !== 3'b101) begin errs++; $display("FAIL simul_both: got %b want 101", {s_stb, m_ack}); end
    step();
    s_ack = 1'b0;
    for (int i = 0; i < 12; i++) begin
      #1;
      vecs++; if (s_stb !== 1'b1) begin errs++; $display("FAIL simul_post_%0d: got %b want 1", i, s_stb); end
      step();
    end
    #1;
    vecs++; if ({s_stb, m_stall} !== 3'b011) begin errs++; $display("FAIL simul_full: got %b want 011", {s_stb, m_stall}); end
    m_cyc = 2'b00; m_stb = 2'b00;
    step();
  endtask

  task automatic test_async_reset();
    m_cyc = 2'b01; m_stb = 2'b01; s_ack = 1'b0;
    step(); step(); step();
    m_stb = 2'b00; #1;
    vecs++; if (s_cyc !== 1'b1) begin errs++; $display("FAIL arst_busy: got %b want 1", s_cyc); end
    #1 rst_n = 1'b0;
    #1;
    vecs++; if ({s_cyc, m_stall, grant, m_err} !== 7'b0110000) begin errs++; $display("FAIL arst_drop: got %b want 0110000", {s_cyc, m_stall, grant, m_err}); end
    m_cyc = 2'b11;
    step(); step();
    rst_n = 1'b1;
    step(); #1;
    vecs++; if (grant !== 2'b01) begin errs++; $display("FAIL arst_first_grant: got %b want 01", grant); end
    m_cyc = 2'b00;
    step();
  endtask

  initial begin
    test_reset();
    test_contention();
    test_burst();
    test_full_stall();
    test_timeout();
    test_simul();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/wb_rr_arbiter.md
# wb_rr_arbiter

Two-master round-robin arbiter placed in front of the single `wb_slave` register core. It grants the pipelined Wishbone bus (with stall) to one master per `cyc` tenure. It tracks outstanding pipelined requests and routes `ack`, `err` and `stall` only to the owner. A watchdog aborts a tenure whose slave stops responding.

## Interface
- `ADDR_WIDTH`, 16: address width.
- `DATA_WIDTH`, 32: data width.
- `GRANULE`, 8: byte-select granule; `SEL_WIDTH` = `DATA_WIDTH/GRANULE`.
- `TIMEOUT`, 64: idle-response cycles before abort; legal range 2..255.
- `MAX_OUTST`, 15: maximum outstanding requests; the counter is 4 bits.

Ports:
- `clk_i`  in  1: the single clock.
- `rst_ni`  in  1: reset, asynchronous, active-low.
- `m_cyc_i`, `m_stb_i`, `m_we_i`  in  2 each: master `cyc`/`stb`/`we`; bit n belongs to master n.
- `m_adr_i`  in  2*ADDR_WIDTH: master addresses, packed, master n in slice n.
- `m_dat_i`  in  2*DATA_WIDTH: master write data, packed.
- `m_sel_i`  in  2*SEL_WIDTH: master byte selects, packed.
- `m_dat_o`  out  DATA_WIDTH: read data; `s_dat_i` broadcast to both masters.
- `m_ack_o`, `m_err_o`, `m_stall_o`  out  2 each: per-master responses.
- `s_cyc_o`, `s_stb_o`, `s_we_o`  out  1 each: slave-side controls.
- `s_adr_o`, `s_dat_o`, `s_sel_o`  out  ADDR_WIDTH / DATA_WIDTH / SEL_WIDTH: slave-side address, write data and selects.
- `s_dat_i`  in  DATA_WIDTH: slave read data.
- `s_ack_i`, `s_err_i`, `s_stall_i`  in  1 each: slave responses.
- `grant_o`  out  2: one-hot current owner; `00` when no owner.
- `timeout_o`  out  1: one-cycle pulse on each abort.

## Operation
- FSM states are IDLE, BUSY and ABORT. State, grant, `last` pointer, outstanding counter and timer are registered. All bus outputs are combinational from these registers and the current inputs.
- **IDLE**
  - `grant_o`=00; `s_cyc_o`/`s_stb_o`=0; `m_stall_o`=11; `m_ack_o`/`m_err_o`=00.
  - If any `m_cyc_i` bit is set: go to BUSY and load the grant.
  - If exactly one master requests, that master is granted.
  - If both request, grant the master ≠ `last`.
  - On every grant, update `last` to the granted master.
- **BUSY, owner g**
  - Forwarding: `s_cyc_o`=`m_cyc_i[g]`; `s_stb_o`=`m_stb_i[g]` & ~full; `we`/`adr`/`dat`/`sel` are muxed from master g.
  - Owner responses: `m_stall_o[g]`=`s_stall_i` | full; `m_ack_o[g]`=`s_ack_i`; `m_err_o[g]`=`s_err_i`.
  - Non-owner: stall=1, ack=0, err=0.
  - Outstanding counter: +1 on accept (`s_stb_o` & ~`s_stall_i`); −1 on `s_ack_i`|`s_err_i`; both in the same cycle leaves it unchanged.
  - full = (counter == `MAX_OUTST`).
  - `m_cyc_i[g]`=0 → go to IDLE and clear the counter. A master dropping `cyc` with outstanding > 0 is a master abort; any late acks are not forwarded.
  - Timer clears when the counter is 0 or on any `s_ack_i`/`s_err_i`. Otherwise it increments.
  - Timer == `TIMEOUT`−1 with counter > 0 → go to ABORT.
- **ABORT**
  - `s_cyc_o`/`s_stb_o`=0; `m_stall_o`=11; slave `ack`/`err` are ignored.
  - In the first ABORT cycle only: `m_err_o[g]`=1 and `timeout_o`=1.
  - The counter clears on entry.
  - Remain in ABORT until `m_cyc_i[g]`=0, then go to IDLE.
- Datapath outputs with no owner (`grant_o`=00) are all zero.
- Reset (`rst_ni` low, async):
  - State IDLE; `last`=1 so master 0 wins the first contention; counter=0; timer=0; `grant_o`=00.
  - Outputs: `s_cyc_o`/`s_stb_o`/`s_we_o`=0; `s_adr_o`/`s_dat_o`/`s_sel_o`=0; `m_ack_o`/`m_err_o`=00; `m_stall_o`=11; `timeout_o`=0.
  - Reset asserted mid-tenure drops `s_cyc_o` immediately; no `err` is issued.

## Timing
- Grant latency is 1 cycle: a request sampled at edge k puts BUSY in effect after edge k. The first `stb` can be forwarded in that cycle.
- Slave-to-master response path is zero added latency (combinational).
- Ownership handoff costs at least one IDLE cycle between tenures. Back-to-back contention alternates 0,1,0,1.
- Timeout: abort is entered on the edge after TIMEOUT consecutive non-responding cycles with counter > 0. The `err` pulse occurs in the following cycle.
- `m_err_o` pulse width in ABORT is exactly 1 cycle, even if master `cyc` stays high for longer.

## Test plan
- **Contention from reset.** Both `m_cyc_i`=11 at the first edge after reset release → `grant_o`=01. Master 0 drops `cyc` after 1 transfer → one IDLE cycle, then `grant_o`=10. Repeat → 01.
- **Pipelined burst.** Master 1 owns the bus; 4 `stb` accepted back-to-back; slave acks each 2 cycles later → counter peaks ≤ 2 and returns to 0. Exactly 4 `m_ack_o[1]` pulses; `m_ack_o[0]`=0 throughout.
- **Full stall.** Slave never acks and `s_stall_i`=0; master streams 15 `stb` → `m_stall_o[g]`=1 and `s_stb_o`=0 at count 15. The next ack drops the count to 14, and one more `stb` is accepted.
- **Timeout.** TIMEOUT=8, one `stb` accepted, no ack → `timeout_o` and `m_err_o[g]` high for 1 cycle, 8 cycles after acceptance. `s_cyc_o`=0 until the master drops `cyc`, then IDLE. A late `s_ack_i` is not forwarded.
- **Simultaneous accept and ack.** `s_stb_o` & ~`s_stall_i` & `s_ack_i` in the same cycle with count=3 → count stays 3.
- **Async reset mid-burst.** `rst_ni` low during BUSY with count=2 → `s_cyc_o`=0 and `m_stall_o`=11 before the next edge. After release, the first contention is granted to master 0.
